// File: rtl/mmio_io_unit.sv
// Memory-mapped I/O unit between the CPU data port and one BRAM port.
// The top quarter of the address space maps output channels, a debounced input bus, change flags and IRQ enables.
module mmio_io_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDRBITS  = 10,
    parameter int unsigned NOUT      = 2,
    parameter int unsigned OUTW      = 10,
    parameter int unsigned INW       = 10,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDRBITS-1:0]    addr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   we,
    input  logic                   re,
    input  logic [WIDTH-1:0]       mem_q,
    output logic                   mem_we,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic [NOUT*OUTW-1:0]   out_ch,
    input  logic [INW-1:0]         in_raw,
    output logic                   irq
);

    localparam int unsigned    CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [3:0]     SEL_IN    = 4'd8;
    localparam logic [3:0]     SEL_CHG   = 4'd9;
    localparam logic [3:0]     SEL_IRQEN = 4'd10;

    logic                       io;
    logic [3:0]                 sel;
    logic                       wr_io;
    logic [NOUT-1:0][OUTW-1:0]  out_q, out_d;
    logic [INW-1:0]             s1_q, s2_q;
    logic [INW-1:0]             cand_q, cand_d;
    logic [INW-1:0]             stable_q, stable_d;
    logic [INW-1:0]             chg_q, chg_d;
    logic [INW-1:0]             irqen_q, irqen_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [WIDTH-1:0]           rd_mux;
    logic [WIDTH-1:0]           rdata_q, rdata_d;
    logic                       rvalid_q, rvalid_d;
    logic                       irq_q, irq_d;
    logic                       unused_ok;

    assign io        = (addr[ADDRBITS-1 -: 2] == 2'b11);
    assign sel       = addr[3:0];
    assign wr_io     = we & io;
    assign mem_we    = we & ~io;
    assign out_ch    = out_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign irq       = irq_q;
    assign unused_ok = ^{addr, wdata};

    always_comb begin
        rd_mux = '0;
        for (int unsigned k = 0; k < NOUT; k++) begin
            if (sel == 4'(k)) rd_mux[OUTW-1:0] = out_q[k];
        end
        case (sel)
            SEL_IN:    rd_mux[INW-1:0] = stable_q;
            SEL_CHG:   rd_mux[INW-1:0] = chg_q;
            SEL_IRQEN: rd_mux[INW-1:0] = irqen_q;
            default:   ;
        endcase
    end

    // Clear is applied first so that a change landing in the same cycle re-sets its bit.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_d    = chg_q;
        if (wr_io && sel == SEL_CHG) chg_d = chg_q & ~wdata[INW-1:0];
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX && cand_q != stable_q) begin
            stable_d = cand_q;
            chg_d    = chg_d | (cand_q ^ stable_q);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        out_d   = out_q;
        irqen_d = irqen_q;
        if (wr_io) begin
            for (int unsigned k = 0; k < NOUT; k++) begin
                if (sel == 4'(k)) out_d[k] = wdata[OUTW-1:0];
            end
            if (sel == SEL_IRQEN) irqen_d = wdata[INW-1:0];
        end
        rdata_d  = rdata_q;
        if (re) rdata_d = io ? rd_mux : mem_q;
        rvalid_d = re;
        irq_d    = |(chg_q & irqen_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            chg_q    <= '0;
            irqen_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            s1_q     <= in_raw;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            irqen_q  <= irqen_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

endmodule
